pipe_stage_chain: RTL and testbench

- Parametrised successor to the fixed per-stage pipeline latches (MEM/WB style) in the 5-stage core.
- A chain of DEPTH register slices, each carrying payload data, destination register index, control bits and a valid flag.
- Adds what the fixed latches lack: per-slice stall (hold), per-slice flush (bubble), bubble insertion behind a stalled slice, and a bubble-at-output counter.
- Used between any two pipeline stages; DEPTH>1 builds multi-cycle stages such as a split memory access.

---
 rtl/pipe_stage_chain_if.sv | 32 +++
 rtl/pipe_stage_chain.sv | 110 +++++++++++
 tb/tb_pipe_stage_chain.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Upstream/downstream bundle for pipe_stage_chain: per-slice stall/flush,
// the incoming instruction fields and the last-slice outputs.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) ();
    logic [DEPTH-1:0]  stall_i;
    logic [DEPTH-1:0]  flush_i;
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic [RD_W-1:0]   rd_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic [RD_W-1:0]   rd_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic              busy_o;

    modport slave (
        input  stall_i, flush_i, valid_i, data_i, rd_i, ctrl_i,
        output valid_o, data_o, rd_o, ctrl_o, bubble_cnt_o, busy_o
    );

    modport master (
        output stall_i, flush_i, valid_i, data_i, rd_i, ctrl_i,
        input  valid_o, data_o, rd_o, ctrl_o, bubble_cnt_o, busy_o
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline register slices with per-slice stall and flush,
// bubble insertion behind a frozen slice and a saturating output-bubble counter.
module pipe_stage_chain #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    pipe_stage_chain_if.slave bus
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [RD_W-1:0]   rd_q   [DEPTH];
    logic [RD_W-1:0]   rd_d   [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];

    logic [DEPTH-1:0]  hold;
    logic [DEPTH-1:0]  up_hold;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [RD_W-1:0]   src_rd   [DEPTH];
    logic [CTRL_W-1:0] src_ctrl [DEPTH];

    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // A stall on any slice also freezes every slice feeding it.
    always_comb begin : hold_chain
        logic acc;
        acc = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc     = acc | bus.stall_i[k];
            hold[k] = acc;
        end
    end

    always_comb begin
        src_v[0]    = bus.valid_i;
        src_data[0] = bus.data_i;
        src_rd[0]   = bus.rd_i;
        src_ctrl[0] = bus.ctrl_i;
        up_hold[0]  = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k]    = valid_q[k-1];
            src_data[k] = data_q[k-1];
            src_rd[k]   = rd_q[k-1];
            src_ctrl[k] = ctrl_q[k-1];
            up_hold[k]  = hold[k-1];
        end
    end

    // Flush, then hold, then bubble-behind-frozen-upstream, then load.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k];
            data_d[k]  = data_q[k];
            rd_d[k]    = rd_q[k];
            ctrl_d[k]  = ctrl_q[k];
            if (bus.flush_i[k] || (!hold[k] && up_hold[k])) begin
                valid_d[k] = 1'b0;
                ctrl_d[k]  = '0;
            end else if (!hold[k]) begin
                valid_d[k] = src_v[k];
                data_d[k]  = src_data[k];
                rd_d[k]    = src_rd[k];
                ctrl_d[k]  = src_v[k] ? src_ctrl[k] : '0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!valid_q[DEPTH-1] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                rd_q[k]   <= '0;
                ctrl_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
                rd_q[k]   <= rd_d[k];
                ctrl_q[k] <= ctrl_d[k];
            end
        end
    end

    assign bus.valid_o      = valid_q[DEPTH-1];
    assign bus.data_o       = data_q[DEPTH-1];
    assign bus.rd_o         = rd_q[DEPTH-1];
    assign bus.ctrl_o       = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign bus.bubble_cnt_o = cnt_q;
    assign bus.busy_o       = |valid_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a DEPTH=3/CNT_W=4 and a DEPTH=2/CNT_W=16 instance
// checked each cycle against a slice-list reference model plus scenario checks.
module tb_pipe_stage_chain;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_stage_chain_if #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .DEPTH(3), .CNT_W(4))  if3 ();
    pipe_stage_chain_if #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .DEPTH(2), .CNT_W(16)) if2 ();

    pipe_stage_chain #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .DEPTH(3), .CNT_W(4)) u3 (
        .clk_i(clk), .rst_i(rst), .bus(if3)
    );
    pipe_stage_chain #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .DEPTH(2), .CNT_W(16)) u2 (
        .clk_i(clk), .rst_i(rst), .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [88:0] obs3, obs2;
    assign obs3 = {if3.valid_o, if3.data_o, if3.rd_o, if3.ctrl_o, if3.busy_o, 12'd0, if3.bubble_cnt_o};
    assign obs2 = {if2.valid_o, if2.data_o, if2.rd_o, if2.ctrl_o, if2.busy_o, if2.bubble_cnt_o};

    // Reference model: one entry per slice, index 0 = youngest.
    logic        mv [2][8];
    logic [63:0] md [2][8];
    logic [4:0]  mr [2][8];
    logic [1:0]  mc [2][8];
    int          mcnt [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            mcnt[u] = 0;
            for (int k = 0; k < 8; k++) begin
                mv[u][k] = 1'b0; md[u][k] = '0; mr[u][k] = '0; mc[u][k] = '0;
            end
        end
    endtask

    task automatic model_step(input int u, input int depth, input int cmax,
                              input logic [7:0] st, input logic [7:0] fl,
                              input logic vin, input logic [63:0] din,
                              input logic [4:0] rin, input logic [1:0] cin);
        logic [7:0] h;
        if (!mv[u][depth-1] && mcnt[u] < cmax) mcnt[u]++;
        h = '0;
        h[depth-1] = st[depth-1];
        for (int k = depth - 2; k >= 0; k--) h[k] = st[k] | h[k+1];
        // Oldest slice first so each slice still sees its upstream's old contents.
        for (int k = depth - 1; k >= 0; k--) begin
            if (fl[k]) begin
                mv[u][k] = 1'b0; mc[u][k] = '0;
            end else if (h[k]) begin
                mv[u][k] = mv[u][k];
            end else if (k > 0 && h[k-1]) begin
                mv[u][k] = 1'b0; mc[u][k] = '0;
            end else if (k == 0) begin
                mv[u][0] = vin; md[u][0] = din; mr[u][0] = rin; mc[u][0] = vin ? cin : 2'b00;
            end else begin
                mc[u][k] = mv[u][k-1] ? mc[u][k-1] : 2'b00;
                mv[u][k] = mv[u][k-1]; md[u][k] = md[u][k-1]; mr[u][k] = mr[u][k-1];
            end
        end
    endtask

    function automatic logic [88:0] expv(input int u, input int depth);
        logic busy;
        busy = 1'b0;
        for (int k = 0; k < depth; k++) busy = busy | mv[u][k];
        return {mv[u][depth-1], md[u][depth-1], mr[u][depth-1], mc[u][depth-1], busy, 16'(mcnt[u])};
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] r, input logic [1:0] c);
        if3.valid_i = v; if3.data_i = d; if3.rd_i = r; if3.ctrl_i = c;
        if2.valid_i = v; if2.data_i = d; if2.rd_i = r; if2.ctrl_i = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0);
        if3.stall_i = '0; if3.flush_i = '0;
        if2.stall_i = '0; if2.flush_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 3, 15, 8'(if3.stall_i), 8'(if3.flush_i),
                   if3.valid_i, if3.data_i, if3.rd_i, if3.ctrl_i);
        model_step(1, 2, 65535, 8'(if2.stall_i), 8'(if2.flush_i),
                   if2.valid_i, if2.data_i, if2.rd_i, if2.ctrl_i);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
            if3.stall_i = 3'($urandom); if2.flush_i = 2'($urandom);
            @(posedge clk); #1;
            checks++;
            if (obs3 !== '0) begin errors++; $display("FAIL reset_u3 got %h want 0", obs3); end
            checks++;
            if (obs2 !== '0) begin errors++; $display("FAIL reset_u2 got %h want 0", obs2); end
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(1'b1, 64'(i + 1), 5'(i + 1), 2'b11);
            else       drive(1'b0, '0, '0, '0);
            tick();
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL fill_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL fill_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            if (i == 2) begin
                checks++;
                if (!(if3.valid_o === 1'b1 && if3.data_o === 64'h1 && if3.bubble_cnt_o === 4'd3))
                    begin errors++; $display("FAIL fill_latency v=%b d=%h cnt=%0d want v=1 d=1 cnt=3",
                                             if3.valid_o, if3.data_o, if3.bubble_cnt_o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_release();
        logic [63:0] got[$];
        int nxt;
        nxt = 1;
        for (int i = 0; i < 20; i++) begin
            idle();
            if3.stall_i = (i == 4 || i == 5) ? 3'b010 : 3'b000;
            if (nxt <= 10) drive(1'b1, 64'(nxt), 5'(nxt), 2'b11);
            if (if3.valid_i && !(|if3.stall_i)) nxt++;
            tick();
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL stall_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL stall_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            if (i == 4 || i == 5) begin
                checks++;
                if (if3.valid_o !== 1'b0 || if3.ctrl_o !== 2'b00)
                    begin errors++; $display("FAIL stall_bubble cyc %0d v=%b c=%b want 0 0", i, if3.valid_o, if3.ctrl_o); end
            end
            if (if3.valid_o === 1'b1) got.push_back(if3.data_o);
            @(negedge clk);
        end
        checks++;
        if (got.size() != 10) begin errors++; $display("FAIL stall_count got %0d want 10", got.size()); end
        for (int j = 0; j < got.size() && j < 10; j++) begin
            checks++;
            if (got[j] !== 64'(j + 1)) begin errors++; $display("FAIL stall_order idx %0d got %h want %h", j, got[j], 64'(j + 1)); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] got[$];
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: drive(1'b1, 64'h11, 5'd1, 2'b11);
                1: begin drive(1'b1, 64'hAA, 5'd2, 2'b11); if2.flush_i = 2'b01; end
                2: drive(1'b1, 64'h33, 5'd3, 2'b11);
                default: ;
            endcase
            tick();
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL flush_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL flush_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            if (i == 2) begin
                checks++;
                if (if2.valid_o !== 1'b0 || if2.ctrl_o !== 2'b00)
                    begin errors++; $display("FAIL flush_slot v=%b c=%b want 0 0", if2.valid_o, if2.ctrl_o); end
            end
            if (if2.valid_o === 1'b1) got.push_back(if2.data_o);
            @(negedge clk);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 64'h11 || got[1] !== 64'h33)
            begin errors++; $display("FAIL flush_seq got %0d items want 11,33", got.size()); end
    endtask

    task automatic test_stall_flush();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: drive(1'b1, 64'h66, 5'd6, 2'b10);
                1: drive(1'b1, 64'h77, 5'd7, 2'b01);
                2: begin drive(1'b1, 64'h99, 5'd9, 2'b11); if2.stall_i = 2'b10; if2.flush_i = 2'b10; end
                default: ;
            endcase
            tick();
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL sf_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            if (i == 2) begin
                checks++;
                if (if2.valid_o !== 1'b0) begin errors++; $display("FAIL sf_bubble v=%b want 0", if2.valid_o); end
            end
            if (i == 3) begin
                checks++;
                if (if2.valid_o !== 1'b1 || if2.data_o !== 64'h77 || if2.ctrl_o !== 2'b01)
                    begin errors++; $display("FAIL sf_emit v=%b d=%h c=%b want 1 77 01", if2.valid_o, if2.data_o, if2.ctrl_o); end
            end
            if (i == 4) begin
                checks++;
                if (if2.valid_o !== 1'b0) begin errors++; $display("FAIL sf_once v=%b want 0", if2.valid_o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL sat_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL sat_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            @(negedge clk);
        end
        checks++;
        if (if3.bubble_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", if3.bubble_cnt_o); end
        checks++;
        if (if2.bubble_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_u2_final got %0d want 20", if2.bubble_cnt_o); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'hC0 + 64'(i), 5'(i), 2'b11);
            tick();
            @(negedge clk);
        end
        if3.stall_i = 3'b111; if2.stall_i = 2'b11;
        tick();
        checks++;
        if (obs3 !== expv(0, 3) || if3.busy_o !== 1'b1)
            begin errors++; $display("FAIL ar_full got %h want %h", obs3, expv(0, 3)); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (obs3 !== '0) begin errors++; $display("FAIL ar_u3_now got %h want 0", obs3); end
        checks++;
        if (obs2 !== '0) begin errors++; $display("FAIL ar_u2_now got %h want 0", obs2); end
        model_reset();
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 64'h55, 5'd7, 2'b01);
            else        drive(1'b0, '0, '0, '0);
            tick();
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL ar_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL ar_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            @(negedge clk);
        end
        checks++;
        if (if3.valid_o !== 1'b1 || if3.data_o !== 64'h55)
            begin errors++; $display("FAIL ar_latency v=%b d=%h want 1 55", if3.valid_o, if3.data_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom), 2'($urandom));
            for (int k = 0; k < 3; k++) begin
                if3.stall_i[k] = ($urandom_range(0, 5) == 0);
                if3.flush_i[k] = ($urandom_range(0, 9) == 0);
            end
            for (int k = 0; k < 2; k++) begin
                if2.stall_i[k] = ($urandom_range(0, 5) == 0);
                if2.flush_i[k] = ($urandom_range(0, 9) == 0);
            end
            tick();
            checks++;
            if (obs3 !== expv(0, 3)) begin errors++; $display("FAIL rand_u3 cyc %0d got %h want %h", i, obs3, expv(0, 3)); end
            checks++;
            if (obs2 !== expv(1, 2)) begin errors++; $display("FAIL rand_u2 cyc %0d got %h want %h", i, obs2, expv(1, 2)); end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        model_reset();
        idle();
        test_reset();
        test_fill();
        test_stall_release();
        test_flush();
        test_stall_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
